// File: rtl/matrix_pkg.sv
// Shared constants and helpers for the matrix unit's shared arithmetic resources.
package matrix_pkg;

  localparam int SQRT_XW  = 20;
  localparam int SQRT_YW  = 10;
  localparam int SQRT_LAT = 6;
  localparam int MAX_N    = 8;

  // One-hot decode of a requester tag; tags at or beyond n decode to zero.
  function automatic logic [MAX_N-1:0] onehot(input logic [2:0] tag, input int n);
    logic [MAX_N-1:0] r;
    r = '0;
    if (int'(tag) < n) r[tag] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: combinational grant searching upward from a
// registered pointer, which moves past the winner whenever advance is asserted.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int TW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  output logic [N-1:0]  o_grant,
  output logic [TW-1:0] o_grant_idx
);

  logic [TW-1:0] r_ptr;
  logic [TW:0]   w_sum;
  logic [TW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    for (int off = 0; off < N; off++) begin
      w_sum = {1'b0, r_ptr} + (TW+1)'(off);
      if (w_sum >= (TW+1)'(N)) w_sum = w_sum - (TW+1)'(N);
      w_idx = w_sum[TW-1:0];
      if (!w_found && i_en && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance && w_found) begin
      r_ptr <= (int'(o_grant_idx) == N - 1) ? '0 : o_grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sqrt_share_arbiter.sv
// Shares one fixed-latency sqrt pipeline among N requesters; a tag/valid shift
// pipe tracks ownership because the core itself has no output-valid.
module sqrt_share_arbiter #(
  parameter  int N        = 4,
  parameter  int XW       = matrix_pkg::SQRT_XW,
  parameter  int YW       = matrix_pkg::SQRT_YW,
  parameter  int SQRT_LAT = matrix_pkg::SQRT_LAT,
  localparam int TW       = $clog2(N),
  localparam int CW       = $clog2(SQRT_LAT + 3)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    req_valid,
  input  logic [N*XW-1:0] req_x,
  output logic [N-1:0]    req_ready,
  output logic            sq_valid,
  output logic [XW-1:0]   sq_x,
  input  logic [YW-1:0]   sq_y,
  output logic [N-1:0]    rsp_valid,
  output logic [YW-1:0]   rsp_y,
  output logic [CW-1:0]   inflight,
  output logic            busy
);

  import matrix_pkg::*;

  logic [N-1:0]  w_grant;
  logic [TW-1:0] w_grant_idx;
  logic          w_accept;
  logic [XW-1:0] w_x_slice [N];
  logic [XW-1:0] w_sel_x;
  logic [N-1:0]  w_rsp_oh;
  logic          w_last;
  logic          w_retire;

  logic            r_sq_valid;
  logic [XW-1:0]   r_sq_x;
  logic [SQRT_LAT:0] r_tv;
  logic [TW-1:0]   r_tag [SQRT_LAT+1];
  logic [N-1:0]    r_rsp_valid;
  logic [YW-1:0]   r_rsp_y;
  logic [CW-1:0]   r_inflight;

  rr_arbiter #(.N(N)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_en        (en),
    .i_req       (req_valid),
    .i_advance   (w_accept),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      assign w_x_slice[gi] = req_x[gi*XW +: XW];
    end
  endgenerate

  assign req_ready = w_grant;
  assign w_accept  = |(req_valid & w_grant);
  assign w_sel_x   = w_x_slice[w_grant_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sq_valid <= 1'b0;
      r_sq_x     <= '0;
    end else begin
      r_sq_valid <= w_accept;
      if (w_accept) r_sq_x <= w_sel_x;
    end
  end

  // Stage 0 loads alongside the issue register, so the last stage lines up
  // with the cycle in which sq_y carries that operand's result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tv <= '0;
    else     r_tv <= {r_tv[SQRT_LAT-1:0], w_accept};
  end

  always_ff @(posedge clk) begin
    r_tag[0] <= w_grant_idx;
    for (int s = 1; s <= SQRT_LAT; s++) r_tag[s] <= r_tag[s-1];
  end

  assign w_last   = r_tv[SQRT_LAT];
  assign w_rsp_oh = N'(onehot(3'(r_tag[SQRT_LAT]), N));
  assign w_retire = |r_rsp_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= '0;
      r_rsp_y     <= '0;
    end else begin
      r_rsp_valid <= w_last ? w_rsp_oh : '0;
      if (w_last) r_rsp_y <= sq_y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_accept, w_retire})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign sq_valid  = r_sq_valid;
  assign sq_x      = r_sq_x;
  assign rsp_valid = r_rsp_valid;
  assign rsp_y     = r_rsp_y;
  assign inflight  = r_inflight;
  assign busy      = (r_inflight != '0);

endmodule

// File: doc/sqrt_share_arbiter.md
Name: sqrt_share_arbiter

Overview:
- Shares one fixed-latency `sqrt_unsigned` pipeline among N requesters in the matrix unit, e.g. norm and scaling lanes.
- Round-robin grants at most one request per cycle and registers it into the sqrt input.
- Tracks which requester owns each in-flight operation with a tag/valid shift pipe, because the sqrt core has no output-valid.
- Routes each result back to its owner as a one-cycle response pulse.

Parameters:
- N, 4, number of requesters (2..8).
- XW, 20, operand width (sqrt input).
- YW, 10, result width (sqrt output).
- SQRT_LAT, 6, cycles from sq_x sampled by the core to sq_y valid.
- TW, $clog2(N), tag width (derived, localparam).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  issue enable; 0 freezes new grants, in-flight ops still drain.
- req_valid  in  N  request present per requester.
- req_x  in  N*XW  operand per requester, slice i = [i*XW +: XW].
- req_ready  out  N  one-hot grant; the request is accepted when req_valid[i] && req_ready[i].
- sq_valid  out  1  drives sqrt valid_in.
- sq_x  out  XW  drives sqrt x.
- sq_y  in  YW  sqrt y_10Q10.
- rsp_valid  out  N  one-cycle result pulse, at most one bit set.
- rsp_y  out  YW  result, qualified by rsp_valid.
- inflight  out  $clog2(SQRT_LAT+3)  ops accepted but not yet responded.
- busy  out  1  inflight != 0.

Behaviour:
- Reset (async, while rst=1) values:
  - sq_valid=0, sq_x=0, rsp_valid=0, rsp_y=0.
  - tag pipe valids all 0, rr pointer=0, inflight=0, busy=0.
- Grant (combinational):
  - If en=0, req_ready=0.
  - Otherwise req_ready is one-hot on the first i with req_valid[i]=1, searching from rr_ptr upward with wrap-around.
  - If no request is valid, req_ready=0.
  - req_ready must not depend on any requester's own req_ready.
- Pointer: on an accept by requester g, rr_ptr <= (g+1) mod N. Otherwise rr_ptr holds.
- Issue register: on accept at edge k, sq_x <= req_x[g] and sq_valid <= 1 during cycle k+1. With no accept, sq_valid <= 0 and sq_x holds.
- Tag pipe, SQRT_LAT+1 stages of {valid, tag}:
  - Stage 0 is loaded with {sq_valid, g} in lockstep with the issue register.
  - Each stage shifts every cycle and never stalls.
  - When the last stage is valid, sq_y is the matching result.
- Response register:
  - rsp_valid <= onehot(tag) when the last stage is valid, else 0.
  - rsp_y <= sq_y on a valid last stage; otherwise rsp_y holds.
  - Accept at edge k gives rsp_valid high during cycle k+SQRT_LAT+2 only.
  - Consumers cannot backpressure; the response must be taken in that cycle.
- Throughput: one accept per cycle sustained; back-to-back results arrive in accept order.
- inflight counter:
  - +1 on accept, -1 on rsp_valid pulse, net 0 when both occur in the same cycle.
  - Never exceeds SQRT_LAT+2.
- Reset mid-operation:
  - All tag valids clear and in-flight results are discarded.
  - Garbage on sq_y (the core has no reset) must never produce rsp_valid.
- en=0 mid-stream: pending pipeline entries still complete and respond.
- Operand edge values: x=0 gives y=0, because the core handles zero; the arbiter does not special-case it.

Decomposition:
- Shared package `matrix_pkg`:
  - SQRT_XW=20, SQRT_YW=10, SQRT_LAT=6 constants.
  - A function onehot(tag, N).
- One natural sub-module: `rr_arbiter` (N-way round-robin, combinational grant, registered pointer, `advance` input), reusable by other shared matrix resources.
- The tag pipe and counter stay inline.
- `sqrt_unsigned` is instantiated at the parent level, not inside this block, so the bench can substitute a behavioural model.

Test Plan:
- Single request:
  - Stimulus: reset, N=4, req_valid=0001, req_x[0]=400, en=1.
  - Required: req_ready=0001 in cycle 0; rsp_valid=0001 with rsp_y=20 exactly 8 cycles after accept.
  - Required: inflight goes 1 then back to 0.
- All-request round-robin:
  - Stimulus: all four requesters valid continuously.
  - Required: grants in order 0,1,2,3,0 on consecutive cycles.
  - Required: responses arrive in the same order, 8 cycles later, one per cycle.
  - Operands 0, 1, 1046529, 65536 give results 0, 1, 1023, 256.
- Wrap and skip:
  - Stimulus: rr_ptr=3 (after a grant to 2); only requesters 1 and 3 valid.
  - Required: grant 3, then 1, then 3.
  - Required: requesters 0 and 2 are never granted.
- en gating:
  - Stimulus: en=0 while 2 ops are in flight and req_valid=1111.
  - Required: req_ready=0.
  - Required: both pending results still pulse; busy falls after the last one.
  - Required: after en=1, granting resumes from the saved rr_ptr.
- Reset mid-flight:
  - Stimulus: 3 ops in flight, assert rst for 1 cycle, keep the core output at arbitrary values.
  - Required: rsp_valid stays 0 for 10 following cycles; inflight=0; rr_ptr=0.
- Simultaneous accept and retire:
  - Stimulus: steady single-requester stream, one accept per cycle.
  - Required: inflight saturates at 8 and holds.
  - Required: no rsp_valid cycles are lost or duplicated over 100 operations.
